glitc_intercom_cmd_sequencer: RTL and testbench

Sequences the GLITC intercom command stream. It collects sync, ping, pong and train requests from the control logic and arbitrates them on a fixed command-slot grid. It drives the one-hot command-select inputs of the intercom command map, one command per slot. As an optional feature, it also measures ping round-trip latency.

---
 rtl/glitc_intercom_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_glitc_intercom_cmd_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/glitc_intercom_cmd_sequencer.sv
// glitc_intercom_cmd_sequencer
// Collects sync/ping/pong/train requests and arbitrates them on a fixed
// command-slot grid. Only one one-hot command select is high per slot.
// Optional ping round-trip timer: define GLITC_INTERCOM_PING_TIMER_EN.
module glitc_intercom_cmd_sequencer #(
  parameter int SLOT_LEN     = 4,
  parameter int TRAIN_SLOTS  = 64,
  parameter int PING_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sync_req_i,
  input  logic        ping_req_i,
  input  logic        pong_req_i,
  input  logic        train_req_i,
  input  logic        pong_rx_i,
  output logic        sync_o,
  output logic        ping_o,
  output logic        pong_o,
  output logic        train_o,
  output logic        slot_start_o,
  output logic [3:0]  ack_o,
  output logic        busy_o,
  output logic [15:0] latency_o,
  output logic        latency_valid_o,
  output logic        timeout_o
);

  localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PING,
    ST_PONG,
    ST_TRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] slot_cnt;
  logic          running;     // low only until the first edge after reset
  logic          boundary;
  logic [3:0]    req_in;      // {train, pong, ping, sync}
  logic [3:0]    req;
  logic [3:0]    pend_q, pend_d;
  logic [15:0]   train_left_q, train_left_d;
  logic [15:0]   train_rem;
  logic [3:0]    ack_d;
  logic          slot_start_q;
  logic [3:0]    ack_q;
  logic          busy_q;

  assign req_in   = {train_req_i, pong_req_i, ping_req_i, sync_req_i};
  assign req      = pend_q | req_in;
  assign boundary = running && (slot_cnt == CW'(SLOT_LEN - 1));
  // Slots remaining once the current slot ends (a TRAIN slot consumes one).
  assign train_rem = train_left_q - {15'd0, state_q == ST_TRAIN};

  // Slot grid: the first edge after reset opens slot 0, then free-running wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      slot_cnt     <= '0;
      running      <= 1'b0;
      slot_start_q <= 1'b0;
    end else begin
      running      <= 1'b1;
      slot_start_q <= !running || boundary;
      if (running) slot_cnt <= boundary ? '0 : slot_cnt + 1'b1;
    end
  end

  // FSM and pending/training registers; busy lags them by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      train_left_q <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      train_left_q <= train_left_d;
      ack_q        <= ack_d;
      busy_q       <= (pend_q != '0) || (train_left_q != '0);
    end
  end

  // Fixed-priority arbitration on boundary cycles: sync > ping > pong > train.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    state_d      = state_q;
    pend_d       = pend_q | req_in;
    train_left_d = train_left_q;
    ack_d        = '0;
    if (boundary) begin
      pend_d       = req;
      train_left_d = train_rem;
      if (state_q == ST_TRAIN && train_rem == '0) ack_d[3] = 1'b1;
      if (req[0]) begin
        state_d   = ST_SYNC;
        pend_d[0] = 1'b0;
        ack_d[0]  = 1'b1;
      end else if (req[1]) begin
        state_d   = ST_PING;
        pend_d[1] = 1'b0;
        ack_d[1]  = 1'b1;
      end else if (req[2]) begin
        state_d   = ST_PONG;
        pend_d[2] = 1'b0;
        ack_d[2]  = 1'b1;
      end else if (train_rem != '0) begin
        state_d = ST_TRAIN;
      end else if (req[3]) begin
        state_d      = ST_TRAIN;
        train_left_d = 16'(TRAIN_SLOTS);
        pend_d[3]    = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign sync_o       = (state_q == ST_SYNC);
  assign ping_o       = (state_q == ST_PING);
  assign pong_o       = (state_q == ST_PONG);
  assign train_o      = (state_q == ST_TRAIN);
  assign slot_start_o = slot_start_q;
  assign ack_o        = ack_q;
  assign busy_o       = busy_q;

`ifdef GLITC_INTERCOM_PING_TIMER_EN
  logic        tmr_run;
  logic [15:0] tmr_cnt;
  logic [15:0] latency_q;
  logic        latency_valid_q;
  logic        timeout_q;
  logic        ping_start;

  assign ping_start = boundary && (state_d == ST_PING);

  // Ping round-trip timer; a new ping slot restarts it silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_run         <= 1'b0;
      tmr_cnt         <= '0;
      latency_q       <= '0;
      latency_valid_q <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      latency_valid_q <= 1'b0;
      timeout_q       <= 1'b0;
      if (ping_start) begin
        tmr_run <= 1'b1;
        tmr_cnt <= '0;
      end else if (tmr_run) begin
        if (pong_rx_i) begin
          latency_q       <= tmr_cnt;
          latency_valid_q <= 1'b1;
          tmr_run         <= 1'b0;
        end else if (tmr_cnt == 16'(PING_TIMEOUT - 1)) begin
          timeout_q <= 1'b1;
          tmr_run   <= 1'b0;
        end else begin
          tmr_cnt <= tmr_cnt + 16'd1;
        end
      end
    end
  end

  assign latency_o       = latency_q;
  assign latency_valid_o = latency_valid_q;
  assign timeout_o       = timeout_q;
`else
  logic unused_pong_rx;
  assign unused_pong_rx  = pong_rx_i;
  assign latency_o       = '0;
  assign latency_valid_o = 1'b0;
  assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_glitc_intercom_cmd_sequencer.sv
// Self-checking bench for glitc_intercom_cmd_sequencer: directed scenarios
// followed by random requests, all compared against a slot-level model.
module tb_glitc_intercom_cmd_sequencer;

  localparam int SLOT_LEN     = 4;
  localparam int TRAIN_SLOTS  = 3;
  localparam int PING_TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        sync_req_i = 1'b0, ping_req_i = 1'b0, pong_req_i = 1'b0;
  logic        train_req_i = 1'b0, pong_rx_i = 1'b0;
  logic        sync_o, ping_o, pong_o, train_o, slot_start_o, busy_o;
  logic [3:0]  ack_o;
  logic [15:0] latency_o;
  logic        latency_valid_o, timeout_o;

  always #5 clk = ~clk;

  glitc_intercom_cmd_sequencer #(
    .SLOT_LEN(SLOT_LEN), .TRAIN_SLOTS(TRAIN_SLOTS), .PING_TIMEOUT(PING_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .sync_req_i(sync_req_i), .ping_req_i(ping_req_i), .pong_req_i(pong_req_i),
    .train_req_i(train_req_i), .pong_rx_i(pong_rx_i),
    .sync_o(sync_o), .ping_o(ping_o), .pong_o(pong_o), .train_o(train_o),
    .slot_start_o(slot_start_o), .ack_o(ack_o), .busy_o(busy_o),
    .latency_o(latency_o), .latency_valid_o(latency_valid_o), .timeout_o(timeout_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per clock edge) -------------
  typedef enum int {C_IDLE, C_SYNC, C_PING, C_PONG, C_TRAIN} cmd_e;

  cmd_e        m_cmd;
  bit   [3:0]  m_pend;        // {train, pong, ping, sync}
  int          m_train_left;
  int          m_pos;         // position in slot, -1 before the first slot
  int          m_cyc;         // cycle index since reset release
  bit          m_slot_start, m_busy, m_latv, m_to, m_ping_live;
  bit   [3:0]  m_ack;
  int          m_ping_start;
  logic [15:0] m_lat;

  task automatic model_reset();
    m_cmd = C_IDLE; m_pend = '0; m_train_left = 0; m_pos = -1; m_cyc = 0;
    m_slot_start = 0; m_busy = 0; m_latv = 0; m_to = 0; m_ping_live = 0;
    m_ack = '0; m_ping_start = 0; m_lat = '0;
  endtask

  task automatic model_step(input bit [3:0] rq, input bit prx);
    bit [3:0] req;
    int       rem;
    bit       ping_go;
    m_busy  = (m_pend != 0) || (m_train_left != 0);
    m_ack   = '0;
    m_latv  = 0;
    m_to    = 0;
    ping_go = 0;
    if (m_pos == SLOT_LEN - 1) begin
      req = m_pend | rq;
      rem = m_train_left - ((m_cmd == C_TRAIN) ? 1 : 0);
      if (m_cmd == C_TRAIN && rem == 0) m_ack[3] = 1;
      if (req[0])       begin m_cmd = C_SYNC; req[0] = 0; m_ack[0] = 1; end
      else if (req[1])  begin m_cmd = C_PING; req[1] = 0; m_ack[1] = 1; ping_go = 1; end
      else if (req[2])  begin m_cmd = C_PONG; req[2] = 0; m_ack[2] = 1; end
      else if (rem > 0)       m_cmd = C_TRAIN;
      else if (req[3])  begin m_cmd = C_TRAIN; rem = TRAIN_SLOTS; req[3] = 0; end
      else                    m_cmd = C_IDLE;
      m_pend       = req;
      m_train_left = rem;
    end else begin
      m_pend = m_pend | rq;
    end
`ifdef GLITC_INTERCOM_PING_TIMER_EN
    if (ping_go) begin
      m_ping_live  = 1;
      m_ping_start = m_cyc + 1;
    end else if (m_ping_live) begin
      if (prx) begin
        m_lat       = 16'(m_cyc - m_ping_start);
        m_latv      = 1;
        m_ping_live = 0;
      end else if (m_cyc - m_ping_start == PING_TIMEOUT - 1) begin
        m_to        = 1;
        m_ping_live = 0;
      end
    end
`else
    if (ping_go && prx) m_ping_live = 0;
`endif
    m_cyc++;
    m_pos = (m_pos == SLOT_LEN - 1) ? 0 : m_pos + 1;
    m_slot_start = (m_pos == 0);
  endtask

  function automatic logic [9:0] exp_ctrl();
    logic [3:0] sel;
    case (m_cmd)
      C_SYNC:  sel = 4'b0001;
      C_PING:  sel = 4'b0010;
      C_PONG:  sel = 4'b0100;
      C_TRAIN: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return {sel, m_slot_start, m_ack, m_busy};
  endfunction

  // Called at a negedge: compare this cycle, drive inputs, advance one edge.
  task automatic cycle(input bit [3:0] rq, input bit prx);
    check("ctrl", {22'd0, train_o, pong_o, ping_o, sync_o, slot_start_o, ack_o, busy_o},
          {22'd0, exp_ctrl()});
    check("timer", {14'd0, latency_o, latency_valid_o, timeout_o},
          {14'd0, m_lat, m_latv, m_to});
    {train_req_i, pong_req_i, ping_req_i, sync_req_i} = rq;
    pong_rx_i = prx;
    @(posedge clk);
    model_step(rq, prx);
    @(negedge clk);
    {train_req_i, pong_req_i, ping_req_i, sync_req_i} = '0;
    pong_rx_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {train_o, pong_o, ping_o, sync_o, slot_start_o, ack_o, busy_o,
                latency_o, latency_valid_o, timeout_o}, 32'd0);
  endtask

  initial begin
    model_reset();
    #1 check_all_zero("reset_t0");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("in_reset");
    end
    rst_i = 1'b0;

    // Idle: slot_start every SLOT_LEN cycles, nothing else.
    repeat (13) cycle(4'b0000, 1'b0);

    // Sync, ping and pong together mid-slot.
    cycle(4'b0111, 1'b0);
    repeat (16) cycle(4'b0000, 1'b0);

    // Training burst, sync arriving in the second train slot.
    cycle(4'b1000, 1'b0);
    for (int k = 0; k < 40 && !(train_o && m_train_left == 2 && m_pos == 1); k++)
      cycle(4'b0000, 1'b0);
    check("second_train_slot", {31'd0, train_o}, 32'd1);
    cycle(4'b0001, 1'b0);
    repeat (24) cycle(4'b0000, 1'b0);
    check("train_busy_clear", {31'd0, busy_o}, 32'd0);

    // Ping answered in cycle 10 of the ping slot.
    cycle(4'b0010, 1'b0);
    for (int k = 0; k < 40 && !(ping_o && slot_start_o); k++) cycle(4'b0000, 1'b0);
    check("ping_slot_start", {30'd0, ping_o, slot_start_o}, 32'd3);
    repeat (10) cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
`ifdef GLITC_INTERCOM_PING_TIMER_EN
    check("ping_latency", {15'd0, latency_o, latency_valid_o}, {15'd0, 16'd10, 1'b1});
`else
    check("ping_latency", {15'd0, latency_o, latency_valid_o}, 32'd0);
`endif
    repeat (4) cycle(4'b0000, 1'b0);

    // Ping with no pong in time, then a late pong.
    cycle(4'b0010, 1'b0);
    for (int k = 0; k < 40 && !(ping_o && slot_start_o); k++) cycle(4'b0000, 1'b0);
    check("ping2_slot_start", {30'd0, ping_o, slot_start_o}, 32'd3);
    repeat (20) cycle(4'b0000, 1'b0);
`ifdef GLITC_INTERCOM_PING_TIMER_EN
    check("ping_timeout", {31'd0, timeout_o}, 32'd1);
`else
    check("ping_timeout", {31'd0, timeout_o}, 32'd0);
`endif
    repeat (2) cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    repeat (4) cycle(4'b0000, 1'b0);

    // Reset in the middle of a ping slot with a pong pending.
    cycle(4'b0110, 1'b0);
    for (int k = 0; k < 40 && !(ping_o && m_pos == 1); k++) cycle(4'b0000, 1'b0);
    check("ping_mid_slot", {31'd0, ping_o}, 32'd1);
    rst_i = 1'b1;
    #1 check_all_zero("mid_reset_async");
    model_reset();
    @(negedge clk);
    check_all_zero("mid_reset_held");
    rst_i = 1'b0;
    repeat (16) cycle(4'b0000, 1'b0);

    // Random requests and pong strobes.
    repeat (1500) begin
      bit [3:0] rq;
      for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 11) == 0);
      cycle(rq, $urandom_range(0, 7) == 0);
    end
    repeat (60) cycle(4'b0000, 1'b0);
    check("final_busy", {31'd0, busy_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
